// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath/memory.
// The controller is the master: it takes opcode/zero/mem_ready and drives the control lines.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       we_dm;
    logic       we_ir;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       we_reg;
    logic [1:0] reg_dst;
    logic [1:0] dm2reg;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, we_dm, we_ir, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, we_reg, reg_dst, dm2reg, retire, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, we_dm, we_ir, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, we_reg, reg_dst, dm2reg, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core; memory phases stall on a req/ready handshake.
// Outputs decode from state, with mem_ready/zero/opcode qualifying only the handshake, branch and illegal cases.
module multicycle_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_if.master    bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTEXEC   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.iord      = 1'b0;
        bus.we_dm     = 1'b0;
        bus.we_ir     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'b00;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 2'b00;
        bus.we_reg    = 1'b0;
        bus.reg_dst   = 2'b00;
        bus.dm2reg    = 2'b00;
        bus.retire    = 1'b0;
        bus.illegal   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the instruction
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.we_ir     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_RTEXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEXEC;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    default: begin
                        bus.illegal = 1'b1;
                        bus.retire  = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.we_reg = 1'b1;
                bus.dm2reg = 2'b01;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.we_dm   = 1'b1;
                bus.iord    = 1'b1;
                bus.retire  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.we_reg  = 1'b1;
                bus.reg_dst = 2'b01;
                bus.retire  = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_we     = bus.zero;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDIEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.we_reg = 1'b1;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // $ra gets the PC register as it stands, i.e. before this edge's jump lands
                bus.we_reg  = 1'b1;
                bus.reg_dst = 2'b10;
                bus.dm2reg  = 2'b10;
                bus.pc_src  = 2'b10;
                bus.pc_we   = 1'b1;
                bus.retire  = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, reset corner cases and randomized instruction streams
// checked per cycle against a phase-list model of each instruction.
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       we_dm;
        logic       we_ir;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       we_reg;
        logic [1:0] reg_dst;
        logic [1:0] dm2reg;
        logic       retire;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         wf;
        int         wm;
        int         exp_cyc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c = '{bus.mem_req, bus.iord, bus.we_dm, bus.we_ir, bus.pc_we, bus.pc_src,
              bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.we_reg, bus.reg_dst,
              bus.dm2reg, bus.retire, bus.illegal};
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h03};
    endfunction

    // cycles per instruction from the timing table plus wait states
    function automatic int model_cycles(input logic [5:0] op, input int wf, input int wm);
        int base;
        case (op)
            6'h00:   base = 4;
            6'h23:   base = 5;
            6'h2b:   base = 4;
            6'h04:   base = 3;
            6'h08:   base = 4;
            6'h02:   base = 3;
            6'h03:   base = 3;
            default: base = 2;
        endcase
        return base + wf + ((op == 6'h23 || op == 6'h2b) ? wm : 0);
    endfunction

    // expected control word for a phase, from the per-state output table
    function automatic ctl_t exp_out(input int ph, input logic [5:0] op, input logic rdy, input logic z);
        ctl_t c;
        c = '0;
        case (ph)
            1:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.we_ir = rdy; c.pc_we = rdy; end
            2:  begin c.alu_src_b = 2'b11; c.illegal = !is_legal(op); c.retire = !is_legal(op); end
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4:  begin c.mem_req = 1; c.iord = 1; end
            5:  begin c.we_reg = 1; c.dm2reg = 2'b01; c.retire = 1; end
            6:  begin c.mem_req = 1; c.iord = 1; c.we_dm = 1; c.retire = rdy; end
            7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            8:  begin c.we_reg = 1; c.reg_dst = 2'b01; c.retire = 1; end
            9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_we = z; c.retire = 1; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: begin c.we_reg = 1; c.retire = 1; end
            12: begin c.pc_src = 2'b10; c.pc_we = 1; c.retire = 1; end
            13: begin c.we_reg = 1; c.reg_dst = 2'b10; c.dm2reg = 2'b10; c.pc_src = 2'b10; c.pc_we = 1; c.retire = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Runs one instruction starting at FETCH; returns cycles until the DUT's retire (-1 if none).
    task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm,
                             input bit rnd, output int cyc);
        int q[$];
        int ph, k, waited, n_ret, lim;
        logic rdy;
        bit is_mem;
        q.push_back(1);
        q.push_back(2);
        case (op)
            6'h00: begin q.push_back(7); q.push_back(8); end
            6'h23: begin q.push_back(3); q.push_back(4); q.push_back(5); end
            6'h2b: begin q.push_back(3); q.push_back(6); end
            6'h04: q.push_back(9);
            6'h08: begin q.push_back(10); q.push_back(11); end
            6'h02: q.push_back(12);
            6'h03: q.push_back(13);
            default: ;
        endcase
        cyc = -1; k = 0; waited = 0; n_ret = 0;
        while (q.size() > 0 && k < 200) begin
            @(negedge clk);
            ph     = q[0];
            is_mem = (ph == 1 || ph == 4 || ph == 6);
            lim    = (ph == 1) ? wf : wm;
            rdy    = is_mem ? (waited >= lim) : 1'($urandom);
            bus.mem_ready = rdy;
            bus.opcode    = (ph == 1 && rnd) ? 6'($urandom) : op;
            bus.zero      = (ph == 9) ? z : 1'($urandom);
            #1;
            check("state", 32'(bus.state), 32'(ph));
            check("ctl", 32'(dut_ctl()), 32'(exp_out(ph, op, rdy, bus.zero)));
            if (bus.retire) begin
                n_ret++;
                if (cyc < 0) cyc = k + 1;
            end
            k++;
            if (is_mem && !rdy) waited++;
            else begin
                void'(q.pop_front());
                waited = 0;
            end
        end
        check("instr_done", 32'(q.size()), 32'd0);
        check("retire_cnt", 32'(n_ret), 32'd1);
    endtask

    vec_t vecs[12];
    int   cyc;

    initial begin
        int seq[5];
        logic [5:0] legal_ops[7];
        logic [5:0] op;
        int wf, wm;

        vecs[0]  = '{6'h00, 1'b0, 0, 0, 4};
        vecs[1]  = '{6'h00, 1'b1, 1, 0, 5};
        vecs[2]  = '{6'h23, 1'b0, 3, 2, 10};
        vecs[3]  = '{6'h23, 1'b0, 0, 0, 5};
        vecs[4]  = '{6'h2b, 1'b0, 0, 0, 4};
        vecs[5]  = '{6'h2b, 1'b0, 2, 3, 9};
        vecs[6]  = '{6'h04, 1'b1, 0, 0, 3};
        vecs[7]  = '{6'h04, 1'b0, 0, 0, 3};
        vecs[8]  = '{6'h08, 1'b0, 0, 0, 4};
        vecs[9]  = '{6'h02, 1'b0, 0, 0, 3};
        vecs[10] = '{6'h03, 1'b0, 0, 0, 3};
        vecs[11] = '{6'h3f, 1'b0, 1, 0, 3};
        legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h03};
        seq = '{1, 2, 3, 6, 6};

        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'h00;
        bus.zero      = 1'b0;
        @(negedge clk); #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ctl", 32'(dut_ctl()), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_state", 32'(bus.state), 32'd0);
        check("post_rst_ctl", 32'(dut_ctl()), 32'd0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].z, vecs[i].wf, vecs[i].wm, 1'b0, cyc);
            check($sformatf("cycles_v%0d", i), 32'(cyc), 32'(vecs[i].exp_cyc));
        end

        // reset while a store is stalled waiting on memory
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.opcode    = 6'h2b;
            bus.mem_ready = (i == 0);
            #1;
            check("sw_walk_state", 32'(bus.state), 32'(seq[i]));
        end
        check("sw_stall_req", 32'({bus.mem_req, bus.we_dm, bus.iord}), 32'b111);
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_ctl", 32'(dut_ctl()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_release_ctl", 32'(dut_ctl()), 32'd0);
        check("abort_release_state", 32'(bus.state), 32'd0);
        run_instr(6'h00, 1'b0, 0, 0, 1'b0, cyc);
        check("resume_cycles", 32'(cyc), 32'd4);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) < 7) op = legal_ops[$urandom_range(0, 6)];
            else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            run_instr(op, 1'($urandom), wf, wm, 1'b1, cyc);
            check($sformatf("rnd_cycles_op%0h", op), 32'(cyc), 32'(model_cycles(op, wf, wm)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
